// File: rtl/duft_ctrl_chain_param.sv
// duft_ctrl_chain_param: parametrised DUFT controller.
// A memory-mapped register front end on an ap_ctrl_chain handshake feeds an
// opcode FSM that drives one DUT through a functional run or a single-step
// DFT scan session (DUMP_NBR dump words per step, up to MAX_STEPS steps).
// Optional feature: define DUFT_CYCLE_CNT_EN to add a 32-bit run-cycle
// counter readable at address 0x03 (reads 0 when undefined).
module duft_ctrl_chain_param #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DUMP_NBR  = 1,
    parameter int unsigned MAX_STEPS = 16
) (
    input  logic                         clk,
    input  logic                         ap_rst,
    input  logic [31:0]                  addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_wr,
    input  logic                         ap_start,
    input  logic                         ap_continue,
    output logic                         ap_idle,
    output logic                         ap_ready,
    output logic                         ap_done,
    output logic [DATA_W-1:0]            ap_return,
    output logic [DATA_W-1:0]            dut_in,
    output logic                         dut_start,
    input  logic                         dut_done,
    input  logic [DATA_W-1:0]            dut_out,
    output logic                         dut_clk_en,
    input  logic [DUMP_NBR*DATA_W-1:0]   dft_dump
);

    localparam logic [31:0] ADDR_OPCODE   = 32'h0000_0000;
    localparam logic [31:0] ADDR_STATUS   = 32'h0000_0001;
    localparam logic [31:0] ADDR_CONFIG   = 32'h0000_0002;
    localparam logic [31:0] ADDR_CYCLE    = 32'h0000_0003;
    localparam logic [31:0] ADDR_DUT_IN   = 32'h0000_0010;
    localparam logic [31:0] ADDR_DUT_OUT  = 32'h0000_0018;
    localparam logic [31:0] ADDR_DFT_BASE = 32'h0000_0020;
    localparam logic [31:0] ADDR_TEST_IN  = 32'hFF00_0000;
    localparam logic [31:0] ADDR_TEST_OUT = 32'hFF00_0001;

    localparam logic [7:0] LAST_STEP = 8'(MAX_STEPS - 1);

    typedef enum logic [1:0] {A_IDLE, A_BUSY, A_DONE} acc_t;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_INPUT_DUT   = 4'd2,
        S_INPUT_RDY   = 4'd3,
        S_OUTPUT_WAIT = 4'd4,
        S_OUTPUT_VAL  = 4'd5,
        S_SCAN_PREP   = 4'd7,
        S_SCAN        = 4'd8,
        S_SCAN_RD     = 4'd9,
        S_TICK        = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_INPUT = 3'd1,
        OP_RUN   = 3'd2,
        OP_ENDR  = 3'd3,
        OP_TEST  = 3'd4,
        OP_NEXT  = 3'd5,
        OP_ENDT  = 3'd6
    } op_t;

    acc_t                acc_st;
    logic [31:0]         acc_addr;
    logic                acc_rd;
    logic [DATA_W-1:0]   acc_wdata;

    logic [DATA_W-1:0]   reg_opcode;
    logic [DATA_W-1:0]   reg_config;
    logic [DATA_W-1:0]   reg_dut_in;
    logic [DATA_W-1:0]   reg_dut_out;
    logic [DATA_W-1:0]   reg_test_in;
    logic [DATA_W-1:0]   dft_out [DUMP_NBR];

    state_t              state;
    logic                commit;
    logic                err;
    logic                step_limit;
    logic [7:0]          step_cnt;

    logic [DATA_W-1:0]   status;
    logic [DATA_W-1:0]   rdata;
    logic [DATA_W-1:0]   cyc_rd;

    logic                op_write;
    logic [2:0]          op_code;
    logic                op_high;
    logic                op_legal;
    logic                op_bad;
    logic                op_go;

    // Opcode decode: only an OPCODE write in its A_BUSY cycle is acted on
    always_comb begin
        op_write = (acc_st == A_BUSY) && !acc_rd && (acc_addr == ADDR_OPCODE);
        op_code  = acc_wdata[2:0];
        op_high  = |acc_wdata[DATA_W-1:3];
        op_legal = 1'b0;
        case (op_code)
            OP_NONE:  op_legal = 1'b1;
            OP_INPUT: op_legal = (state == S_IDLE);
            OP_RUN:   op_legal = (state == S_INPUT_RDY);
            OP_TEST:  op_legal = (state == S_INPUT_RDY);
            OP_ENDR:  op_legal = (state == S_OUTPUT_VAL);
            OP_NEXT:  op_legal = (state == S_SCAN_RD);
            OP_ENDT:  op_legal = (state == S_SCAN_RD);
            default:  op_legal = 1'b0;
        endcase
        op_bad = op_write && (op_high || !op_legal);
        op_go  = op_write && !op_high && op_legal;
    end

`ifdef DUFT_CYCLE_CNT_EN
    logic [31:0] cyc_cnt;

    // Run-cycle counter: restarts on RUN, counts OUTPUT_WAIT cycles, holds once dut_done arrives
    always_ff @(posedge clk) begin
        if (ap_rst) begin
            cyc_cnt <= '0;
        end else if (op_go && (state == S_INPUT_RDY) && (op_code == OP_RUN)) begin
            cyc_cnt <= '0;
        end else if ((state == S_OUTPUT_WAIT) && !dut_done) begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end

    assign cyc_rd = DATA_W'(cyc_cnt);
`else
    assign cyc_rd = '0;
`endif

    // Read mux: STATUS assembly and address decode of the latched access
    always_comb begin
        status        = '0;
        status[3:0]   = state;
        status[4]     = commit;
        status[5]     = err;
        status[6]     = step_limit;
        status[19:12] = step_cnt;

        rdata = '0;
        case (acc_addr)
            ADDR_OPCODE:   rdata = reg_opcode;
            ADDR_STATUS:   rdata = status;
            ADDR_CONFIG:   rdata = reg_config;
            ADDR_CYCLE:    rdata = cyc_rd;
            ADDR_DUT_IN:   rdata = reg_dut_in;
            ADDR_DUT_OUT:  rdata = reg_dut_out;
            ADDR_TEST_OUT: rdata = reg_test_in;
            default:       rdata = '0;
        endcase
        for (int unsigned i = 0; i < DUMP_NBR; i++) begin
            if (acc_addr == ADDR_DFT_BASE + i) begin
                rdata = dft_out[i];
            end
        end
    end

    // Access handshake FSM plus host-writable registers
    always_ff @(posedge clk) begin
        if (ap_rst) begin
            acc_st      <= A_IDLE;
            acc_addr    <= '0;
            acc_rd      <= 1'b0;
            acc_wdata   <= '0;
            ap_idle     <= 1'b1;
            ap_ready    <= 1'b0;
            ap_done     <= 1'b0;
            ap_return   <= '0;
            reg_opcode  <= '0;
            reg_config  <= '0;
            reg_dut_in  <= '0;
            reg_test_in <= '0;
        end else begin
            ap_ready <= 1'b0;
            case (acc_st)
                A_IDLE: begin
                    if (ap_start) begin
                        acc_addr  <= addr;
                        acc_rd    <= rd_wr;
                        acc_wdata <= wr_data;
                        ap_ready  <= 1'b1;
                        ap_idle   <= 1'b0;
                        acc_st    <= A_BUSY;
                    end
                end
                A_BUSY: begin
                    if (!acc_rd) begin
                        case (acc_addr)
                            ADDR_OPCODE:  reg_opcode  <= acc_wdata;
                            ADDR_CONFIG:  reg_config  <= acc_wdata;
                            ADDR_DUT_IN:  reg_dut_in  <= acc_wdata;
                            ADDR_TEST_IN: reg_test_in <= acc_wdata;
                            default:      ;
                        endcase
                    end
                    ap_return <= acc_rd ? rdata : '0;
                    ap_done   <= 1'b1;
                    acc_st    <= A_DONE;
                end
                A_DONE: begin
                    if (ap_continue) begin
                        ap_done <= 1'b0;
                        ap_idle <= 1'b1;
                        acc_st  <= A_IDLE;
                    end
                end
                default: begin
                    ap_done <= 1'b0;
                    ap_idle <= 1'b1;
                    acc_st  <= A_IDLE;
                end
            endcase
        end
    end

    // Control FSM: opcode-driven run/scan sequencing with registered DUT controls
    always_ff @(posedge clk) begin
        if (ap_rst) begin
            state       <= S_IDLE;
            dut_in      <= '0;
            dut_start   <= 1'b0;
            dut_clk_en  <= 1'b0;
            commit      <= 1'b0;
            err         <= 1'b0;
            step_limit  <= 1'b0;
            step_cnt    <= '0;
            reg_dut_out <= '0;
            for (int unsigned i = 0; i < DUMP_NBR; i++) begin
                dft_out[i] <= '0;
            end
        end else begin
            // Illegal opcodes flag err; automatic state progress below still applies
            if (op_bad) begin
                err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (op_go && (op_code == OP_INPUT)) begin
                        dut_in     <= reg_dut_in;
                        commit     <= 1'b0;
                        err        <= 1'b0;
                        step_limit <= 1'b0;
                        step_cnt   <= '0;
                        state      <= S_INPUT_DUT;
                    end
                end
                S_INPUT_DUT: begin
                    state <= S_INPUT_RDY;
                end
                S_INPUT_RDY: begin
                    if (op_go && (op_code == OP_RUN)) begin
                        dut_start  <= 1'b1;
                        dut_clk_en <= 1'b1;
                        state      <= S_OUTPUT_WAIT;
                    end else if (op_go && (op_code == OP_TEST)) begin
                        dut_start  <= 1'b1;
                        dut_clk_en <= 1'b1;
                        state      <= S_SCAN_PREP;
                    end
                end
                S_OUTPUT_WAIT: begin
                    if (dut_done) begin
                        reg_dut_out <= dut_out;
                        commit      <= 1'b1;
                        dut_start   <= 1'b0;
                        dut_clk_en  <= 1'b0;
                        state       <= S_OUTPUT_VAL;
                    end
                end
                S_OUTPUT_VAL: begin
                    if (op_go && (op_code == OP_ENDR)) begin
                        state <= S_IDLE;
                    end
                end
                S_SCAN_PREP: begin
                    dut_start  <= 1'b0;
                    dut_clk_en <= 1'b0;
                    state      <= S_SCAN;
                end
                S_SCAN: begin
                    for (int unsigned i = 0; i < DUMP_NBR; i++) begin
                        dft_out[i] <= dft_dump[i*DATA_W +: DATA_W];
                    end
                    state <= S_SCAN_RD;
                end
                S_SCAN_RD: begin
                    if (op_go && (op_code == OP_ENDT)) begin
                        state <= S_IDLE;
                    end else if (op_go && (op_code == OP_NEXT)) begin
                        if (step_cnt == LAST_STEP) begin
                            step_limit <= 1'b1;
                            err        <= 1'b1;
                        end else begin
                            dut_clk_en <= 1'b1;
                            state      <= S_TICK;
                        end
                    end
                end
                S_TICK: begin
                    if (dut_done) begin
                        commit      <= 1'b1;
                        reg_dut_out <= dut_out;
                    end
                    if (step_cnt != 8'hFF) begin
                        step_cnt <= step_cnt + 8'd1;
                    end
                    dut_clk_en <= 1'b0;
                    state      <= S_SCAN;
                end
                default: begin
                    dut_start  <= 1'b0;
                    dut_clk_en <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_duft_ctrl_chain_param.sv
// Scoreboard bench for duft_ctrl_chain_param (DATA_W=32, DUMP_NBR=2, MAX_STEPS=10).
// The DUT model finishes on its 9th enabled cycle with dut_out = dut_in + 8 and
// presents dump word j = dut_in + step + j.
module tb_duft_ctrl_chain_param;

    localparam int DW = 32;
    localparam int DN = 2;
    localparam int MS = 10;

    localparam logic [31:0] A_OPCODE  = 32'h00;
    localparam logic [31:0] A_STATUS  = 32'h01;
    localparam logic [31:0] A_CONFIG  = 32'h02;
    localparam logic [31:0] A_CYCLE   = 32'h03;
    localparam logic [31:0] A_DUT_IN  = 32'h10;
    localparam logic [31:0] A_DUT_OUT = 32'h18;
    localparam logic [31:0] A_DFT0    = 32'h20;
    localparam logic [31:0] A_DFT1    = 32'h21;
    localparam logic [31:0] A_TIN     = 32'hFF000000;
    localparam logic [31:0] A_TOUT    = 32'hFF000001;

    logic              clk = 1'b0;
    logic              ap_rst = 1'b1;
    logic [31:0]       addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic              rd_wr = 1'b0;
    logic              ap_start = 1'b0;
    logic              ap_continue = 1'b1;
    logic              ap_idle, ap_ready, ap_done;
    logic [DW-1:0]     ap_return;
    logic [DW-1:0]     dut_in;
    logic              dut_start;
    logic              dut_done;
    logic [DW-1:0]     dut_out;
    logic              dut_clk_en;
    logic [DN*DW-1:0]  dft_dump;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    bit          chk_q [$];
    string       nm_q  [$];

    duft_ctrl_chain_param #(.DATA_W(DW), .DUMP_NBR(DN), .MAX_STEPS(MS)) dut (
        .clk(clk), .ap_rst(ap_rst), .addr(addr), .wr_data(wr_data), .rd_wr(rd_wr),
        .ap_start(ap_start), .ap_continue(ap_continue), .ap_idle(ap_idle),
        .ap_ready(ap_ready), .ap_done(ap_done), .ap_return(ap_return),
        .dut_in(dut_in), .dut_start(dut_start), .dut_done(dut_done),
        .dut_out(dut_out), .dut_clk_en(dut_clk_en), .dft_dump(dft_dump)
    );

    always #5 clk = ~clk;

    // DUT model: counts enabled cycles per job (job starts on a dut_start rise)
    logic start_q = 1'b0;
    int   en_cnt  = 0;
    int   cur;
    int   step;

    always_comb begin
        cur  = (dut_start && !start_q) ? 0 : en_cnt;
        step = (en_cnt > 0) ? en_cnt - 1 : 0;
        dft_dump = '0;
        for (int j = 0; j < DN; j++) begin
            dft_dump[j*DW +: DW] = dut_in + 32'(step) + 32'(j);
        end
    end

    assign dut_done = dut_clk_en && (cur == 8);
    assign dut_out  = dut_in + 32'd8;

    always @(posedge clk) begin
        if (dut_clk_en) en_cnt <= cur + 1;
        start_q <= dut_start;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each ap_done rise, also checks one ap_ready pulse per access
    int  ready_cnt = 0;
    bit  done_q = 1'b0;
    always @(negedge clk) begin
        if (ap_rst) begin
            ready_cnt = 0;
        end else begin
            if (ap_ready) ready_cnt++;
            if (ap_done && !done_q) begin
                check("ap_ready_pulses", 32'(ready_cnt), 32'd1);
                ready_cnt = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    bit          c;
                    string       n;
                    e = exp_q.pop_front();
                    c = chk_q.pop_front();
                    n = nm_q.pop_front();
                    if (c) check(n, ap_return, e);
                end
            end
        end
        done_q = ap_done;
    end

    task automatic access(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp, input string nm, input int hold);
        int n;
        exp_q.push_back(exp);
        chk_q.push_back(rd);
        nm_q.push_back(nm);
        n = 0;
        while (!ap_idle && n < 50) begin @(posedge clk); #1; n++; end
        if (!ap_idle) check({nm, "_idle_timeout"}, 32'(ap_idle), 32'd1);
        addr = a; wr_data = wd; rd_wr = rd; ap_start = 1'b1;
        @(posedge clk); #1;
        ap_start = 1'b0;
        n = 0;
        while (!ap_done && n < 50) begin @(posedge clk); #1; n++; end
        if (!ap_done) check({nm, "_done_timeout"}, 32'(ap_done), 32'd1);
        if (hold > 0) begin
            ap_continue = 1'b0;
            repeat (hold) @(posedge clk);
            #1;
            check("ap_done_held", 32'(ap_done), 32'd1);
            ap_continue = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        access(1'b0, a, d, 32'd0, "write", 0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        access(1'b1, a, 32'd0, exp, nm, 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] cyc_exp;
`ifdef DUFT_CYCLE_CNT_EN
        cyc_exp = 32'd8;
`else
        cyc_exp = 32'd0;
`endif
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ap_idle",    32'(ap_idle),    32'd1);
        check("rst_ap_ready",   32'(ap_ready),   32'd0);
        check("rst_ap_done",    32'(ap_done),    32'd0);
        check("rst_ap_return",  ap_return,       32'd0);
        check("rst_dut_start",  32'(dut_start),  32'd0);
        check("rst_dut_clk_en", 32'(dut_clk_en), 32'd0);
        check("rst_dut_in",     dut_in,          32'd0);
        ap_rst = 1'b0;
        idle_cycles(1);
        rd(A_STATUS, 32'h0, "status_after_reset");

        // Handshake and loopback; first access holds ap_done until ap_continue
        access(1'b0, A_TIN, 32'h7216, 32'd0, "write_test_in", 3);
        rd(A_TOUT, 32'h7216, "test_out");
        wr(A_CONFIG, 32'h00A5A5A5);
        rd(A_CONFIG, 32'h00A5A5A5, "config");
        rd(32'h30, 32'h0, "unmapped_0x30");
        rd(A_DFT0 + DN, 32'h0, "dft_beyond_dump_nbr");
        rd(32'hFF000002, 32'h0, "unmapped_high");

        // Functional run
        wr(A_DUT_IN, 32'h7216);
        rd(A_DUT_IN, 32'h7216, "dut_in_reg");
        wr(A_OPCODE, 32'd1);
        rd(A_STATUS, 32'h3, "status_input_rdy");
        rd(A_OPCODE, 32'd1, "opcode_readback");
        check("dut_in_port", dut_in, 32'h7216);
        wr(A_OPCODE, 32'd2);
        idle_cycles(20);
        rd(A_STATUS, 32'h15, "status_output_val");
        rd(A_DUT_OUT, 32'h721E, "dut_out_run");
        rd(A_CYCLE, cyc_exp, "cycle_count");
        wr(A_OPCODE, 32'd3);
        rd(A_STATUS, 32'h10, "status_after_endr");

        // Illegal opcodes in IDLE
        wr(A_OPCODE, 32'd2);
        rd(A_STATUS, 32'h30, "status_run_in_idle");
        wr(A_OPCODE, 32'd9);
        rd(A_STATUS, 32'h30, "status_op_gt6");

        // Scan session
        wr(A_OPCODE, 32'd1);
        rd(A_STATUS, 32'h3, "status_input_clears");
        wr(A_OPCODE, 32'd4);
        idle_cycles(3);
        rd(A_DFT0, 32'h7216, "dft0_step0");
        rd(A_DFT1, 32'h7217, "dft1_step0");
        rd(A_STATUS, 32'h9, "status_scan_rd");
        for (int k = 1; k < MS; k++) begin
            wr(A_OPCODE, 32'd5);
            idle_cycles(3);
            rd(A_DFT0, 32'h7216 + 32'(k), $sformatf("dft0_step%0d", k));
            rd(A_DFT1, 32'h7217 + 32'(k), $sformatf("dft1_step%0d", k));
            rd(A_STATUS, 32'h9 | (32'(k) << 12) | ((k >= 8) ? 32'h10 : 32'h0),
               $sformatf("status_step%0d", k));
        end
        rd(A_DUT_OUT, 32'h721E, "dut_out_scan");
        wr(A_OPCODE, 32'd5);
        rd(A_STATUS, 32'h9079, "status_step_limit");
        wr(A_OPCODE, 32'd6);
        rd(A_STATUS, 32'h9070, "status_after_endt");

        // Reset during OUTPUT_WAIT
        wr(A_DUT_IN, 32'h100);
        wr(A_OPCODE, 32'd1);
        wr(A_OPCODE, 32'd2);
        idle_cycles(2);
        check("run_dut_start", 32'(dut_start), 32'd1);
        ap_rst = 1'b1;
        @(posedge clk); #1;
        ap_rst = 1'b0;
        check("rst_mid_dut_start",  32'(dut_start),  32'd0);
        check("rst_mid_dut_clk_en", 32'(dut_clk_en), 32'd0);
        check("rst_mid_ap_idle",    32'(ap_idle),    32'd1);
        rd(A_STATUS, 32'h0, "status_after_mid_reset");
        rd(A_DUT_IN, 32'h0, "dut_in_after_mid_reset");

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
            if (exp_q.size() != 0) check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
